// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port valid/ready memory.
// One transaction in flight at a time; a programmable timeout turns a silent memory into an error.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  req1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  grant_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  winner;
  logic                  issue, resp;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_rd_d      = wr_rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    // On a tie the requester that did not win last time goes first.
    winner = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;

    case (state_q)
      StIdle: begin
        if (req0_valid_i || req1_valid_i) begin
          grant_d      = winner;
          last_grant_d = winner;
          wr_rd_d      = winner ? req1_wr_rd_i : req0_wr_rd_i;
          addr_d       = winner ? req1_addr_i  : req0_addr_i;
          wdata_d      = winner ? req1_wdata_i : req0_wdata_i;
          cnt_d        = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (mem_ready_i) begin
          rdata_d = wr_rd_q ? '0 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue        = (state_q == StIssue);
    resp         = (state_q == StResp);
    mem_valid_o  = issue;
    mem_wr_rd_o  = issue & wr_rd_q;
    mem_addr_o   = issue ? addr_q : '0;
    mem_wdata_o  = issue ? wdata_q : '0;
    req0_ready_o = resp & ~grant_q;
    req1_ready_o = resp & grant_q;
    req0_rdata_o = req0_ready_o ? rdata_q : '0;
    req1_rdata_o = req1_ready_o ? rdata_q : '0;
    req0_err_o   = req0_ready_o & err_q;
    req1_err_o   = req1_ready_o & err_q;
    busy_o       = issue | resp;
    grant_o      = grant_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wr_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_rd_q      <= wr_rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory (configurable wait / never-ready).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_wr_rd, req1_valid, req1_wr_rd;
  logic [8:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, req0_err, req1_err;
  logic [15:0] req0_rdata, req1_rdata;
  logic        mem_valid, mem_wr_rd, mem_ready;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, grant;

  int tests = 0;
  int fails = 0;

  int  mem_wait  = 0;
  bit  mem_never = 1'b0;
  int  wcnt      = 0;
  bit [15:0] mem_array [512];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(9), .WIDTH(16), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_wr_rd_i(req0_wr_rd), .req0_addr_i(req0_addr),
    .req0_wdata_i(req0_wdata), .req0_ready_o(req0_ready), .req0_rdata_o(req0_rdata),
    .req0_err_o(req0_err),
    .req1_valid_i(req1_valid), .req1_wr_rd_i(req1_wr_rd), .req1_addr_i(req1_addr),
    .req1_wdata_i(req1_wdata), .req1_ready_o(req1_ready), .req1_rdata_o(req1_rdata),
    .req1_err_o(req1_err),
    .mem_valid_o(mem_valid), .mem_wr_rd_o(mem_wr_rd), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .grant_o(grant)
  );

  // Memory model: ready after mem_wait cycles of mem_valid, or never.
  assign mem_ready = mem_valid && !mem_never && (wcnt == mem_wait);
  assign mem_rdata = mem_array[mem_addr];

  always @(posedge clk) begin
    if (mem_valid && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_valid && mem_ready && mem_wr_rd) mem_array[mem_addr] <= mem_wdata;
  end

  task automatic test_reset();
    logic [71:0] outs;
    rst = 1'b1; req0_valid = 1'b1; req0_wr_rd = 1'b0; req0_addr = 9'h000; req0_wdata = 16'h0;
    req1_valid = 1'b0; req1_wr_rd = 1'b0; req1_addr = 9'h000; req1_wdata = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {req0_ready, req1_ready, req0_rdata, req1_rdata, req0_err, req1_err, mem_valid,
              mem_wr_rd, mem_addr, mem_wdata, busy, grant};
      tests++;
      if (outs !== 72'h0) begin
        fails++; $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_valid !== 1'b1 || grant !== 1'b0) begin
      fails++; $display("FAIL reset_first_grant: mem_valid=%b grant=%b want 1/0", mem_valid, grant);
    end
    @(negedge clk);
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL reset_first_ready: got %b want 1", req0_ready);
    end
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    req0_valid = 1'b1; req0_wr_rd = 1'b1; req0_addr = 9'h005; req0_wdata = 16'hA5A5;
    @(negedge clk);
    tests++;
    if ({mem_valid, mem_wr_rd, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h005, 16'hA5A5}) begin
      fails++; $display("FAIL wr_issue: got v=%b w=%b a=%h d=%h want 1 1 005 a5a5",
                        mem_valid, mem_wr_rd, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if ({req0_ready, req0_err, mem_valid, req1_ready, req1_rdata} !== {3'b100, 1'b0, 16'h0}) begin
      fails++; $display("FAIL wr_resp: got rdy=%b err=%b mv=%b r1=%b r1d=%h want 1 0 0 0 0",
                        req0_ready, req0_err, mem_valid, req1_ready, req1_rdata);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      fails++; $display("FAIL wr_idle: busy=%b rdy=%b want 0 0", busy, req0_ready);
    end
    req0_valid = 1'b1; req0_wr_rd = 1'b0; req0_wdata = 16'h0;
    @(negedge clk);
    tests++;
    if ({mem_valid, mem_wr_rd, mem_addr} !== {2'b10, 9'h005}) begin
      fails++; $display("FAIL rd_issue: got v=%b w=%b a=%h want 1 0 005",
                        mem_valid, mem_wr_rd, mem_addr);
    end
    @(negedge clk);
    tests++;
    if ({req0_ready, req0_rdata, req0_err, mem_valid, req1_ready, req1_err, req1_rdata} !==
        {1'b1, 16'hA5A5, 4'b0000, 16'h0}) begin
      fails++; $display("FAIL rd_resp: got rdy=%b d=%h err=%b mv=%b r1=%b want 1 a5a5 0 0 0",
                        req0_ready, req0_rdata, req0_err, mem_valid, req1_ready);
    end
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [8:0] exp_addr [4];
    bit         exp_grant [4];
    int k = 0;
    bit pend0 = 1'b0, pend1 = 1'b0;
    exp_addr  = '{9'h010, 9'h020, 9'h010, 9'h020};
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_wr_rd = 1'b0; req0_addr = 9'h010;
    req1_valid = 1'b1; req1_wr_rd = 1'b0; req1_addr = 9'h020;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (pend0) begin req0_valid = 1'b1; pend0 = 1'b0; end
      if (pend1) begin req1_valid = 1'b1; pend1 = 1'b0; end
      if (req0_ready) begin req0_valid = 1'b0; pend0 = 1'b1; end
      if (req1_ready) begin req1_valid = 1'b0; pend1 = 1'b1; end
      if (mem_valid) begin
        tests++;
        if (mem_addr !== exp_addr[k] || grant !== exp_grant[k]) begin
          fails++; $display("FAIL contention_%0d: got addr=%h grant=%b want %h %b",
                            k, mem_addr, grant, exp_addr[k], exp_grant[k]);
        end
        k++;
      end
    end
    tests++;
    if (k != 4) begin
      fails++; $display("FAIL contention_count: got %0d grants want 4", k);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int  cnt = 0;
    bit  got = 1'b0;
    mem_never = 1'b1;
    req1_valid = 1'b1; req1_wr_rd = 1'b0; req1_addr = 9'h1FF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        cnt++;
        if (cnt == 1) begin
          tests++;
          if (mem_addr !== 9'h1FF || grant !== 1'b1) begin
            fails++; $display("FAIL timeout_addr: got %h g=%b want 1ff 1", mem_addr, grant);
          end
        end
      end
      if (req1_ready) begin
        got = 1'b1;
        tests++;
        if ({req1_err, req1_rdata, req0_ready, req0_err} !== {1'b1, 16'h0, 2'b00}) begin
          fails++; $display("FAIL timeout_resp: got err=%b d=%h r0=%b want 1 0000 0",
                            req1_err, req1_rdata, req0_ready);
        end
        req1_valid = 1'b0;
        break;
      end
    end
    tests++;
    if (!got || cnt != 15) begin
      fails++; $display("FAIL timeout_cycles: got ready=%b valid_cycles=%0d want 1 15", got, cnt);
    end
    mem_never = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mem_wait = 5;
    req0_valid = 1'b1; req0_wr_rd = 1'b0; req0_addr = 9'h033;
    @(negedge clk);
    tests++;
    if (mem_valid !== 1'b1) begin
      fails++; $display("FAIL rstmid_issue: mem_valid=%b want 1", mem_valid);
    end
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_valid, busy, req0_ready, req1_ready} !== 4'b0000) begin
      fails++; $display("FAIL rstmid_abort: got mv=%b busy=%b r0=%b r1=%b want 0 0 0 0",
                        mem_valid, busy, req0_ready, req1_ready);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req0_ready || req1_ready || mem_valid || busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
    end
    mem_wait = 0;
  endtask

  task automatic test_late_ready();
    int cycles = 0, addr_bad = 0, mr_at = -1, rdy_at = -1;
    mem_wait = 4;
    req0_valid = 1'b1; req0_wr_rd = 1'b0; req0_addr = 9'h005;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) req0_addr = 9'h0AA;
      if (mem_valid) begin
        cycles++;
        if (mem_addr !== 9'h005) addr_bad++;
        if (mem_ready) mr_at = c;
      end
      if (req0_ready) begin
        rdy_at = c;
        tests++;
        if (req0_rdata !== 16'hA5A5 || req0_err !== 1'b0) begin
          fails++; $display("FAIL late_resp: got d=%h err=%b want a5a5 0", req0_rdata, req0_err);
        end
        req0_valid = 1'b0;
        break;
      end
    end
    tests++;
    if (cycles != 5 || addr_bad != 0) begin
      fails++; $display("FAIL late_hold: got cycles=%0d bad_addr=%0d want 5 0", cycles, addr_bad);
    end
    tests++;
    if (mr_at != 4 || rdy_at != mr_at + 1) begin
      fails++; $display("FAIL late_latency: got mem_ready@%0d ready@%0d want 4 5", mr_at, rdy_at);
    end
    mem_wait = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_late_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester, round-robin arbiter placed in front of the single-port `memory` block (512 x 16, valid/ready handshake). It accepts one transaction at a time from either requester and captures its command. It drives the command to the memory and holds it until the memory answers, then returns the response and a one-cycle ready pulse to the granted requester. A programmable timeout aborts a transaction the memory never answers and flags an error instead of hanging.

## Interface
Parameters:
- `ADDR_WIDTH`, 9, address width (matches memory depth 512).
- `WIDTH`, 16, data width.
- `TIMEOUT`, 15, maximum cycles spent in ISSUE waiting for `mem_ready_i`. A value of 0 disables the timeout.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req0_valid_i` / `req1_valid_i` in 1: requester has a command.
- `req0_wr_rd_i` / `req1_wr_rd_i` in 1: 1 = write, 0 = read.
- `req0_addr_i` / `req1_addr_i` in ADDR_WIDTH: command address.
- `req0_wdata_i` / `req1_wdata_i` in WIDTH: write data.
- `req0_ready_o` / `req1_ready_o` out 1: one-cycle completion pulse.
- `req0_rdata_o` / `req1_rdata_o` out WIDTH: read data, valid while the matching ready is high.
- `req0_err_o` / `req1_err_o` out 1: timeout flag, valid while the matching ready is high.
- `mem_valid_o` out 1: command valid to the memory.
- `mem_wr_rd_o` out 1: command direction to the memory.
- `mem_addr_o` out ADDR_WIDTH: command address to the memory.
- `mem_wdata_o` out WIDTH: write data to the memory.
- `mem_ready_i` in 1: memory completion.
- `mem_rdata_i` in WIDTH: read data, valid when `mem_ready_i` is high.
- `busy_o` out 1: high in ISSUE and RESP.
- `grant_o` out 1: index of the current or most recent grant.

## Operation
The FSM has three states: IDLE, ISSUE, RESP.

- **IDLE**
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant `~last_grant`.
  - On grant: register `wr_rd`, `addr` and `wdata` of the winner, set `grant_o` and `last_grant` to the winner, clear the timeout counter, and go to ISSUE.
- **ISSUE**
  - `mem_valid_o` = 1. `mem_*` outputs come from the captured registers and stay stable.
  - If `mem_ready_i` = 1: capture `mem_rdata_i` on reads (0 on writes), set err = 0, go to RESP.
  - Otherwise increment the counter. When TIMEOUT != 0 and the counter reaches TIMEOUT: set err = 1, set rdata = 0, go to RESP.
- **RESP**
  - `mem_valid_o` = 0.
  - The granted `reqN_ready_o` = 1, and `reqN_rdata_o` / `reqN_err_o` are driven. The other requester's outputs are 0.
  - Unconditionally go to IDLE. Requests are not sampled in RESP.

Requester obligations:
- The requester holds valid until it sees ready, and drops valid in the cycle after ready.
- Command fields are sampled only at grant; later changes are ignored.
- Dropping valid after the grant does not cancel the transaction. The ready pulse is still issued.

Other rules:
- The timeout counter width is clog2(TIMEOUT+1). It never wraps.
- The round-robin pointer `last_grant` resets to 1, so requester 0 wins the first tie.
- The pointer updates only on a grant. Single-requester traffic does not starve the other requester once it asserts valid.
- Addresses pass through unmodified; there is no wrap logic. 0x1FF is a legal address.

## Timing
- **Reset:** all outputs are 0, state = IDLE, `last_grant` = 1, counter = 0, `grant_o` = 0.
- **Reset mid-transaction:** on the next edge `mem_valid_o` = 0, no ready pulse is issued, the transaction is lost, and the FSM is in IDLE.
- **Latency:**
  - Valid sampled at edge E0 → `mem_valid_o` high from E0.
  - `mem_ready_i` sampled at edge E1 → `reqN_ready_o` high for exactly one cycle, E1 to E2.
  - IDLE at E2; the next grant is sampled at E3 at the earliest.
- **Throughput:** with zero-wait memory, `mem_valid_o` is high exactly 1 cycle per transaction, for 3 cycles per transaction minimum.
- **Timeout:** `mem_valid_o` is high for exactly TIMEOUT cycles, then RESP with err = 1.
- **`mem_ready_i` while not in ISSUE:** ignored.
- **Both ready and timeout in the same cycle:** `mem_ready_i` wins, err = 0.

## Test plan
1. **Reset:** `rst_i` = 1 for 3 cycles with `req0_valid_i` = 1 → all outputs 0 throughout; first `mem_valid_o` appears one edge after `rst_i` falls.
2. **Write then read:** req0 writes addr 0x005, data 0xA5A5, then reads addr 0x005, against a zero-wait memory model → `mem_valid_o` high 1 cycle each, `req0_ready_o` pulses twice, second pulse has `req0_rdata_o` = 0xA5A5, err = 0, req1 outputs stay 0.
3. **Contention:** both valid continuously after reset (req0 addr 0x010, req1 addr 0x020, reads), each requester re-asserting after its ready pulse → `mem_addr_o` sequence 0x010, 0x020, 0x010, 0x020; `grant_o` = 0, 1, 0, 1.
4. **Timeout:** `mem_ready_i` tied 0, TIMEOUT = 15, req1 reads 0x1FF → `mem_valid_o` high exactly 15 cycles, then `req1_ready_o` = 1 with `req1_err_o` = 1 and `req1_rdata_o` = 0.
5. **Reset mid-ISSUE:** memory wait of 5 cycles, assert `rst_i` at ISSUE cycle 2 → `mem_valid_o` = 0 next edge, no ready pulse to either requester, `busy_o` = 0.
6. **Late ready / field change:** memory ready after 4 wait cycles; requester changes addr to 0x0AA after grant → `mem_addr_o` keeps the originally granted address for all 5 cycles; ready pulse arrives 1 cycle after `mem_ready_i`.
